// File: rtl/mycpu_defs.sv
// Shared fetch-side definitions: datapath width, pc step and fetch FSM encoding.
package mycpu_defs;
    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Single-entry instruction buffer toward decode with valid/ready handshake and a kill input.
module fetch_buf #(
    parameter int XLEN = mycpu_defs::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_inst_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            kill_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            inst_d  = load_inst_i;
            pc_d    = load_pc_i;
        end else if (kill_i || ready_i) begin
            // Contents are kept after consume/kill; only the valid flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o   = valid_q;
    assign inst_o    = inst_q;
    assign inst_pc_o = pc_q;
endmodule

// File: rtl/ifetch_npc.sv
// Fetch FSM: requests the instruction at pc, buffers it toward decode, and computes npc
// (hold / step / redirect) for the PC register.
module ifetch_npc #(
    parameter int XLEN    = mycpu_defs::XLEN,
    parameter int PC_STEP = mycpu_defs::PC_STEP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);
    import mycpu_defs::*;

    fetch_state_e    state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic [XLEN-1:0] redir_tgt;
    logic            buf_load;
    logic            buf_kill;

    assign redir_tgt = redir_target & ~XLEN'(3);
    assign imem_addr = pc;

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        npc           = pc;
        imem_req      = 1'b0;
        buf_load      = 1'b0;
        buf_kill      = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redir_valid || pend_valid_q) begin
                        // Fetched word belongs to the wrong path; refetch at the newest target.
                        npc          = redir_valid ? redir_tgt : pend_target_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        buf_load = 1'b1;
                        npc      = pc + XLEN'(PC_STEP);
                        state_d  = FETCH_HOLD;
                    end
                end else if (redir_valid) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = redir_tgt;
                end
            end
            FETCH_HOLD: begin
                if (redir_valid) begin
                    npc      = redir_tgt;
                    buf_kill = 1'b1;
                    state_d  = FETCH_REQ;
                end else if (inst_ready) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    fetch_buf #(.XLEN(XLEN)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (buf_load),
        .load_inst_i (imem_rdata),
        .load_pc_i   (pc),
        .kill_i      (buf_kill),
        .ready_i     (inst_ready),
        .valid_o     (inst_valid),
        .inst_o      (inst),
        .inst_pc_o   (inst_pc)
    );
endmodule

// File: tb/tb_ifetch_npc.sv
// Bench for ifetch_npc: PC register + memory responder + redirect injector, scoreboard on decode side.
module tb_ifetch_npc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [31:0] inst; logic [31:0] pc; } exp_t;
    exp_t sb[$];

    logic [31:0] model_pc;
    logic [31:0] req_tgt [4];

    ifetch_npc dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // PC register partner: loads npc every cycle, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= npc;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        imem_ack    = 1'b0;
        redir_valid = 1'b0;
        inst_ready  = 1'b0;
        imem_rdata  = $urandom;
    endtask

    // Decode-side monitor: every accepted instruction must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got pc %h with no expected instruction", inst_pc);
                end else begin
                    e = sb.pop_front();
                    chk("accept_inst", inst, e.inst);
                    chk("accept_pc", inst_pc, e.pc);
                    $display("accept pc=%h inst=%h", inst_pc, inst);
                end
            end
        end
    end

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        step();
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_npc", npc, 32'd0);
        step();
        rst_n = 1'b1;
        model_pc = '0;
        // First cycle after release is IDLE: redirects are ignored and npc follows pc.
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0AA0;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        chk("idle_npc", npc, 32'd0);
        $display("reset released");
    endtask

    // One fetch transaction: lat request cycles (ack in the last), redirects on cycles in rmask,
    // then (if delivered) hold idle cycles and a final action: 0 consume, 1 consume+redirect, 2 kill.
    task automatic do_fetch(input int lat, input int rmask, input int hold, input int mode,
                            input logic [31:0] htgt);
        bit          redirected = 1'b0;
        logic [31:0] last_tgt = '0;
        logic [31:0] exp_pc;
        exp_t        e;
        for (int c = 0; c < lat; c++) begin
            step();
            chk("req_on", {31'd0, imem_req}, 32'd1);
            chk("req_addr", imem_addr, model_pc);
            if ((rmask >> c) & 1) begin
                redir_valid  = 1'b1;
                redir_target = req_tgt[c];
                redirected   = 1'b1;
                last_tgt     = req_tgt[c] & 32'hFFFF_FFFC;
            end
            if (c == lat - 1) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(model_pc);
            end
            #1;
            if (c == lat - 1) chk("ack_npc", npc, redirected ? last_tgt : model_pc + 32'd4);
            else              chk("req_npc", npc, model_pc);
        end
        if (redirected) begin
            $display("fetch %h dropped, redirect to %h", model_pc, last_tgt);
            model_pc = last_tgt;
            return;
        end
        exp_pc = model_pc;
        if (mode != 2) begin
            e.inst = mem_word(exp_pc);
            e.pc   = exp_pc;
            sb.push_back(e);
        end
        model_pc = model_pc + 32'd4;
        for (int c = 0; c <= hold; c++) begin
            step();
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_inst", inst, mem_word(exp_pc));
            chk("hold_inst_pc", inst_pc, exp_pc);
            if (c == hold) begin
                inst_ready = (mode != 2);
                if (mode != 0) begin
                    redir_valid  = 1'b1;
                    redir_target = htgt;
                end
            end
            #1;
            if (c == hold && mode != 0) begin
                chk("hold_redir_npc", npc, htgt & 32'hFFFF_FFFC);
            end else begin
                chk("hold_npc", npc, model_pc);
            end
        end
        if (mode != 0) model_pc = htgt & 32'hFFFF_FFFC;
        $display("fetch %h delivered, mode %0d, next %h", exp_pc, mode, model_pc);
    endtask

    initial begin
        model_pc = '0;
        do_reset();
        // Single-cycle ack: npc steps to 0x4 in the ack cycle.
        do_fetch(1, 0, 0, 0, 32'd0);
        // Three-cycle latency, decode always ready.
        do_fetch(3, 0, 0, 0, 32'd0);
        do_fetch(3, 0, 0, 0, 32'd0);
        // Decode stalls for five cycles.
        do_fetch(2, 0, 5, 0, 32'd0);
        // Redirect mid-request, data dropped.
        req_tgt[1] = 32'h0000_0100;
        do_fetch(3, 2, 0, 0, 32'd0);
        chk("redir_100_pc", model_pc, 32'h100);
        // Redirect in HOLD: kill, then consume-and-redirect.
        do_fetch(1, 0, 1, 2, 32'h0000_0200);
        do_fetch(1, 0, 0, 1, 32'h0000_0201);
        // Two redirects in one request: the later wins.
        req_tgt[1] = 32'h0000_0300;
        req_tgt[2] = 32'h0000_0400;
        do_fetch(4, 6, 0, 0, 32'd0);
        // Pending redirect overridden by a redirect arriving with the ack.
        req_tgt[0] = 32'h0000_0500;
        req_tgt[1] = 32'h0000_0600;
        do_fetch(2, 3, 0, 0, 32'd0);
        // Wrap at the top of the address space.
        do_fetch(1, 0, 0, 1, 32'hFFFF_FFFF);
        do_fetch(2, 0, 0, 0, 32'd0);
        chk("wrap_pc", model_pc, 32'd0);
        do_fetch(1, 0, 0, 0, 32'd0);
        // Reset in the middle of a request with a pending redirect.
        step();
        chk("mid_req_on", {31'd0, imem_req}, 32'd1);
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0700;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        do_reset();
        do_fetch(1, 0, 0, 0, 32'd0);
        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int lat;
            int rmask;
            lat = $urandom_range(1, 4);
            rmask = 0;
            if ($urandom_range(0, 3) == 0) rmask = $urandom_range(1, 15) & ((1 << lat) - 1);
            for (int k = 0; k < 4; k++) req_tgt[k] = $urandom;
            do_fetch(lat, rmask, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end
        step();
        step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
